// File: rtl/ogege_pkg.sv
// Shared types and constants for the host-side text area port.
package ogege_pkg;

  localparam int unsigned TEXT_ADDR_W = 7;
  localparam int unsigned TEXT_DATA_W = 8;

  // Edge on which text-side outputs may change; pix_clk rises two cycles later.
  localparam logic [1:0] PIX_PHASE_LAUNCH = 2'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } hp_state_t;

  typedef struct packed {
    logic                   wr;
    logic [TEXT_ADDR_W-1:0] addr;
    logic [TEXT_DATA_W-1:0] data;
  } hp_cmd_t;

endpackage

// File: rtl/text_host_port_if.sv
// Host command/response bus between the CPU and the text host port.
interface text_host_port_if #(
  parameter int unsigned ADDR_W = ogege_pkg::TEXT_ADDR_W,
  parameter int unsigned DATA_W = ogege_pkg::TEXT_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign o_full_c  = (level_q == (AW+1)'(DEPTH));
  assign o_empty_c = (level_q == '0);
  assign o_rdata_c = mem_q[rd_ptr_q];
  assign o_level   = level_q;
  assign do_push   = i_push & ~o_full_c;
  assign do_pop    = i_pop & ~o_empty_c;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_wdata;
    end
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/text_host_port.sv
// Queues CPU register commands and replays each as one pix_clk-wide rd/wr strobe
// into the text area, returning read data as a single-cycle response pulse.
module text_host_port
  import ogege_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = TEXT_ADDR_W,
  parameter int unsigned DATA_W     = TEXT_DATA_W,
  parameter bit          BLANK_ONLY = 1'b0
) (
  input  logic                        clk_100mhz,
  input  logic                        rstn_i,
  input  logic [1:0]                  i_pix_phase,
  input  logic                        i_blank,
  text_host_port_if.slave             host,
  output logic                        o_text_rd,
  output logic                        o_text_wr,
  output logic [ADDR_W-1:0]           o_text_addr,
  output logic [DATA_W-1:0]           o_text_data,
  input  logic [DATA_W-1:0]           i_text_data,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t      push_cmd, head_cmd;
  logic      push, pop, full, empty, launch, issue_ok;

  hp_state_t         state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  assign push_cmd       = cmd_t'{wr: host.cmd_wr, addr: host.cmd_addr, data: host.cmd_data};
  assign push           = host.cmd_valid & ~full;
  assign host.cmd_ready = ~full;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk_100mhz),
    .rst_n     (rstn_i),
    .i_push    (push),
    .i_wdata   (push_cmd),
    .i_pop     (pop),
    .o_rdata_c (head_cmd),
    .o_full_c  (full),
    .o_empty_c (empty),
    .o_level   (o_fifo_level)
  );

  assign launch   = (i_pix_phase == PIX_PHASE_LAUNCH);
  assign issue_ok = ~empty & (!BLANK_ONLY || i_blank);

  // Every text-side change lands on a launch edge, so addr/data settle before pix_clk rises.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    is_rd_d     = is_rd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch && issue_ok) begin
          pop     = 1'b1;
          addr_d  = head_cmd.addr;
          data_d  = head_cmd.data;
          wr_d    = head_cmd.wr;
          rd_d    = ~head_cmd.wr;
          is_rd_d = ~head_cmd.wr;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (launch) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        // Text area has had a full pix period to present read data.
        if (launch) begin
          if (is_rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = i_text_data;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      is_rd_q     <= is_rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_text_rd      = rd_q;
  assign o_text_wr      = wr_q;
  assign o_text_addr    = addr_q;
  assign o_text_data    = data_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_text_host_port.sv
// Directed bench for text_host_port: strobe timing, read response, FIFO full,
// blank gating, reset mid-strobe and an ordered command stream.
module tb_text_host_port;
  import ogege_pkg::*;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    int         len;
    int         ph;
    int         start;
  } ev_t;

  logic       clk_100mhz = 1'b0;
  logic       rstn, rstn2;
  logic [1:0] phase = 2'd0;
  int         cyc = 0;
  logic       blank1 = 1'b0;
  logic       blank2;

  logic       t_rd, t_wr;
  logic [6:0] t_addr;
  logic [7:0] t_data;
  logic [7:0] t_rdata = 8'h00;
  logic [3:0] level;
  logic       t2_rd, t2_wr;
  logic [6:0] t2_addr;
  logic [7:0] t2_data;
  logic [7:0] t2_rdata = 8'h00;
  logic [3:0] level2;

  logic [7:0] tmem [128];
  logic [7:0] shadow [128];

  int n_vec = 0;
  int n_err = 0;

  ev_t        ev_q [$];
  ev_t        ev2_q [$];
  logic [7:0] rsp_q [$];
  int         rsp_len_q [$];
  int         ovl_err = 0, chg_err = 0, min_gap = 1000;

  text_host_port_if hif ();
  text_host_port_if hif2 ();

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) begin
    phase <= phase + 2'd1;
    cyc   <= cyc + 1;
  end

  text_host_port #(.FIFO_DEPTH(8), .BLANK_ONLY(1'b0)) dut (
    .clk_100mhz   (clk_100mhz),
    .rstn_i       (rstn),
    .i_pix_phase  (phase),
    .i_blank      (blank1),
    .host         (hif),
    .o_text_rd    (t_rd),
    .o_text_wr    (t_wr),
    .o_text_addr  (t_addr),
    .o_text_data  (t_data),
    .i_text_data  (t_rdata),
    .o_fifo_level (level)
  );

  text_host_port #(.FIFO_DEPTH(8), .BLANK_ONLY(1'b1)) dut2 (
    .clk_100mhz   (clk_100mhz),
    .rstn_i       (rstn2),
    .i_pix_phase  (phase),
    .i_blank      (blank2),
    .host         (hif2),
    .o_text_rd    (t2_rd),
    .o_text_wr    (t2_wr),
    .o_text_addr  (t2_addr),
    .o_text_data  (t2_data),
    .i_text_data  (t2_rdata),
    .o_fifo_level (level2)
  );

  // Text area model: acts on the pix_clk rise (phase 3 -> 0).
  always @(posedge clk_100mhz) begin
    if (cyc == 0) begin
      for (int i = 0; i < 128; i++) tmem[i] <= 8'(i * 3 + 1);
      tmem[7'h48] <= 8'h03;
    end else if (phase == 2'd3) begin
      if (t_wr) tmem[t_addr] <= t_data;
      if (t_rd) t_rdata <= tmem[t_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe and response monitor for dut.
  initial begin : mon1
    bit   in_s = 1'b0;
    ev_t  cur;
    int   rlen = 0, last_end = -1000;
    logic [7:0] rdat = 8'h00;
    cur = '{wr: 1'b0, addr: 7'h0, data: 8'h0, len: 0, ph: 0, start: 0};
    forever begin
      @(negedge clk_100mhz);
      if (!rstn) begin
        in_s = 1'b0; rlen = 0; last_end = -1000;
      end else begin
        if (t_rd && t_wr) ovl_err++;
        if (t_rd || t_wr) begin
          if (!in_s) begin
            in_s = 1'b1;
            cur.wr = t_wr; cur.addr = t_addr; cur.data = t_data;
            cur.len = 1; cur.ph = int'(phase); cur.start = cyc;
            if (cyc - last_end < min_gap) min_gap = cyc - last_end;
          end else begin
            cur.len++;
            if (t_addr != cur.addr || t_data != cur.data || t_wr != cur.wr) chg_err++;
          end
        end else if (in_s) begin
          in_s = 1'b0; last_end = cyc; ev_q.push_back(cur);
        end
        if (hif.rsp_valid) begin
          rlen++; rdat = hif.rsp_data;
        end else if (rlen > 0) begin
          rsp_q.push_back(rdat); rsp_len_q.push_back(rlen); rlen = 0;
        end
      end
    end
  end

  // Strobe-start monitor for dut2.
  initial begin : mon2
    logic prev = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clk_100mhz);
      if (t2_rd && t2_wr) ovl_err++;
      if (t2_wr && !prev) begin
        e = '{wr: 1'b1, addr: t2_addr, data: t2_data, len: 0, ph: int'(phase), start: cyc};
        ev2_q.push_back(e);
      end
      prev = t2_wr;
    end
  end

  task automatic push_cmd(input logic wr, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    hif.cmd_valid = 1'b1; hif.cmd_wr = wr; hif.cmd_addr = a; hif.cmd_data = d;
    while (!hif.cmd_ready && n < 200) begin
      @(negedge clk_100mhz); n++;
    end
    if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    hif.cmd_valid = 1'b0;
  endtask

  task automatic push2(input logic [6:0] a, input logic [7:0] d, output bit acc);
    hif2.cmd_valid = 1'b1; hif2.cmd_wr = 1'b1; hif2.cmd_addr = a; hif2.cmd_data = d;
    acc = hif2.cmd_ready;
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    hif2.cmd_valid = 1'b0;
  endtask

  task automatic get_ev(input string tag, output ev_t e);
    int n = 0;
    while (ev_q.size() == 0 && n < 100) begin
      @(negedge clk_100mhz); n++;
    end
    chk(tag, 32'(ev_q.size() > 0), 32'd1);
    if (ev_q.size() > 0) e = ev_q.pop_front();
    else e = '{wr: 1'bx, addr: 7'hx, data: 8'hx, len: -1, ph: -1, start: -1};
  endtask

  task automatic get_ev2(input string tag, output ev_t e);
    int n = 0;
    while (ev2_q.size() == 0 && n < 40) begin
      @(negedge clk_100mhz); n++;
    end
    chk(tag, 32'(ev2_q.size() > 0), 32'd1);
    if (ev2_q.size() > 0) e = ev2_q.pop_front();
    else e = '{wr: 1'bx, addr: 7'hx, data: 8'hx, len: -1, ph: -1, start: -1};
  endtask

  initial begin : stim
    ev_t        e;
    bit         acc;
    int         n, c0, exp_start;
    logic [1:0] dp;
    hp_cmd_t    c;
    hp_cmd_t    exp_q [$];
    logic [7:0] exp_rsp [$];

    rstn = 1'b0; rstn2 = 1'b0; blank2 = 1'b0;
    hif.cmd_valid = 1'b0; hif.cmd_wr = 1'b0; hif.cmd_addr = '0; hif.cmd_data = '0;
    hif2.cmd_valid = 1'b0; hif2.cmd_wr = 1'b0; hif2.cmd_addr = '0; hif2.cmd_data = '0;
    repeat (3) @(negedge clk_100mhz);

    chk("rst_wr", 32'(t_wr), 32'd0);
    chk("rst_rd", 32'(t_rd), 32'd0);
    chk("rst_addr", 32'(t_addr), 32'd0);
    chk("rst_ready", 32'(hif.cmd_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rsp", 32'(hif.rsp_valid), 32'd0);

    rstn = 1'b1; rstn2 = 1'b1;
    repeat (2) @(negedge clk_100mhz);

    // Single write: 4-clock strobe launched into phase 2.
    push_cmd(1'b1, 7'h46, 8'h62);
    get_ev("wr_seen", e);
    chk("wr_kind", 32'(e.wr), 32'd1);
    chk("wr_addr", 32'(e.addr), 32'h46);
    chk("wr_data", 32'(e.data), 32'h62);
    chk("wr_len", 32'(e.len), 32'd4);
    chk("wr_phase", 32'(e.ph), 32'd2);

    // Single read of 0x48 (model holds 0x03).
    push_cmd(1'b0, 7'h48, 8'h00);
    get_ev("rd_seen", e);
    chk("rd_kind", 32'(e.wr), 32'd0);
    chk("rd_addr", 32'(e.addr), 32'h48);
    chk("rd_len", 32'(e.len), 32'd4);
    n = 0;
    while (rsp_q.size() == 0 && n < 40) begin
      @(negedge clk_100mhz); n++;
    end
    chk("rsp_seen", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) begin
      chk("rsp_data", 32'(rsp_q.pop_front()), 32'h03);
      chk("rsp_len", 32'(rsp_len_q.pop_front()), 32'd1);
    end
    repeat (10) @(negedge clk_100mhz);
    chk("rsp_hold", 32'(hif.rsp_data), 32'h03);

    // Blank-gated instance: command waits while i_blank=0.
    push2(7'h10, 8'hAA, acc);
    chk("b_acc", 32'(acc), 32'd1);
    repeat (100) @(negedge clk_100mhz);
    chk("b_no_strobe", 32'(ev2_q.size()), 32'd0);
    chk("b_level", 32'(level2), 32'd1);
    blank2 = 1'b1;
    c0 = cyc;
    dp = 2'd1 - phase;
    exp_start = c0 + int'(dp) + 1;
    get_ev2("b_seen", e);
    chk("b_start", 32'(e.start), 32'(exp_start));
    chk("b_phase", 32'(e.ph), 32'd2);
    chk("b_addr", 32'(e.addr), 32'h10);
    blank2 = 1'b0;

    // Fill: 8 accepted, 9th refused while nothing drains.
    for (int i = 0; i < 9; i++) begin
      push2(7'(i + 32), 8'(i), acc);
      chk($sformatf("f_acc%0d", i), 32'(acc), 32'(i < 8));
    end
    chk("f_level", 32'(level2), 32'd8);
    chk("f_ready", 32'(hif2.cmd_ready), 32'd0);
    blank2 = 1'b1;
    n = 0;
    while (!hif2.cmd_ready && n < 20) begin
      @(negedge clk_100mhz); n++;
    end
    chk("f_ready_back", 32'(hif2.cmd_ready), 32'd1);
    chk("f_level7", 32'(level2), 32'd7);

    // Reset while a write strobe is high.
    push_cmd(1'b1, 7'h01, 8'h11);
    push_cmd(1'b1, 7'h02, 8'h22);
    push_cmd(1'b1, 7'h03, 8'h33);
    n = 0;
    while (!t_wr && n < 50) begin
      @(negedge clk_100mhz); n++;
    end
    chk("rs_seen", 32'(t_wr), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rs_wr", 32'(t_wr), 32'd0);
    chk("rs_level", 32'(level), 32'd0);
    chk("rs_ready", 32'(hif.cmd_ready), 32'd1);
    repeat (3) @(negedge clk_100mhz);
    rstn = 1'b1;
    ev_q.delete();
    @(negedge clk_100mhz);
    push_cmd(1'b1, 7'h55, 8'h99);
    get_ev("rs2_seen", e);
    chk("rs2_addr", 32'(e.addr), 32'h55);
    chk("rs2_data", 32'(e.data), 32'h99);
    chk("rs2_len", 32'(e.len), 32'd4);
    repeat (30) @(negedge clk_100mhz);
    chk("rs_no_stale", 32'(ev_q.size()), 32'd0);

    // Ordered random command stream against a shadow memory.
    for (int i = 0; i < 128; i++) shadow[i] = tmem[i];
    ev_q.delete(); rsp_q.delete(); rsp_len_q.delete();
    for (int k = 0; k < 16; k++) begin
      c.wr   = 1'($urandom_range(0, 1));
      c.addr = 7'($urandom_range(0, 127));
      c.data = 8'($urandom);
      push_cmd(c.wr, c.addr, c.data);
      exp_q.push_back(c);
      if (c.wr) shadow[c.addr] = c.data;
      else exp_rsp.push_back(shadow[c.addr]);
    end
    n = 0;
    while ((ev_q.size() < 16 || rsp_q.size() < exp_rsp.size()) && n < 600) begin
      @(negedge clk_100mhz); n++;
    end
    chk("r_ev_count", 32'(ev_q.size()), 32'd16);
    chk("r_rsp_count", 32'(rsp_q.size()), 32'(exp_rsp.size()));
    foreach (exp_q[k]) begin
      if (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        chk($sformatf("r_kind%0d", k), 32'(e.wr), 32'(exp_q[k].wr));
        chk($sformatf("r_addr%0d", k), 32'(e.addr), 32'(exp_q[k].addr));
        if (exp_q[k].wr) chk($sformatf("r_data%0d", k), 32'(e.data), 32'(exp_q[k].data));
      end
    end
    foreach (exp_rsp[k]) begin
      if (rsp_q.size() > 0) begin
        chk($sformatf("r_rsp%0d", k), 32'(rsp_q.pop_front()), 32'(exp_rsp[k]));
        chk($sformatf("r_rsplen%0d", k), 32'(rsp_len_q.pop_front()), 32'd1);
      end
    end

    chk("no_overlap", 32'(ovl_err), 32'd0);
    chk("stable_strobe", 32'(chg_err), 32'd0);
    chk("gap_min", 32'(min_gap >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
